// File: rtl/led_pkg.sv
// led_pkg: mode codes, direction constants and the mode type shared by the LED pattern engine.
package led_pkg;
  typedef enum logic [2:0] {
    CHASE_L = 3'd0,
    CHASE_R = 3'd1,
    BOUNCE  = 3'd2,
    FILL    = 3'd3,
    BLINK   = 3'd4
  } mode_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: speed-selectable divider producing a one-cycle terminal pulse.
module tick_prescaler #(
  parameter int BASE_DIV = 25_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] speed,
  output logic       tick_raw
);
  logic [DIV_W-1:0] count_q, count_d, tc;
  logic [31:0]      shifted;
  always_comb begin
    shifted  = 32'(BASE_DIV) >> speed;
    tc       = (shifted == 32'd0) ? '0 : DIV_W'(shifted - 32'd1);
    tick_raw = en && !clr && (count_q == tc);
    // a count left above a freshly lowered terminal restarts at 0 without a pulse
    count_d  = (clr || (en && count_q >= tc)) ? '0 : count_q + DIV_W'(en);
  end
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) count_q <= '0;
    else       count_q <= count_d;
endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: chase/bounce/fill/blink LED pattern FSM with prescaler, hold/step and position readout.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int N_LED    = 18,
  parameter int BASE_DIV = 25_000_000,
  parameter int DIV_W    = 26,
  parameter int POS_W    = $clog2(N_LED + 1)
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [3:0]       speed,
  input  logic             hold,
  input  logic             step,
  output logic [N_LED-1:0] LEDR,
  output logic [POS_W-1:0] pos,
  output logic [2:0]       mode_active,
  output logic             tick
);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] FULL = POS_W'(N_LED);
  mode_t            mode_active_q, mode_active_d;
  logic [POS_W-1:0] pos_q, pos_d, top;
  logic             dir_q, dir_d, phase_q, phase_d, tick_q, tick_d;
  logic             mode_chg, adv, tick_raw, turn;
  logic [N_LED:0]   one_hot;
  assign mode_chg = mode != mode_active_q;
  tick_prescaler #(.BASE_DIV(BASE_DIV), .DIV_W(DIV_W)) u_presc (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .en      (en),
    .clr     (mode_chg),
    .speed   (speed),
    .tick_raw(tick_raw)
  );
  always_comb begin
    adv           = en && (hold ? step : tick_raw);
    top           = (mode_active_q == FILL) ? FULL : LAST;
    // bounce/fill turn around on the end value itself so each end is shown once
    turn          = (dir_q == DIR_UP) ? (pos_q == top) : (pos_q == '0);
    mode_active_d = mode_active_q;
    pos_d         = pos_q;
    dir_d         = dir_q;
    phase_d       = phase_q;
    tick_d        = adv && !mode_chg;
    if (mode_chg) begin
      mode_active_d = mode_t'(mode);
      pos_d         = '0;
      dir_d         = DIR_UP;
      phase_d       = 1'b0;
    end else if (adv) begin
      case (mode_active_q)
        CHASE_L: pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
        CHASE_R: pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
        BOUNCE, FILL: begin
          dir_d = dir_q ^ turn;
          pos_d = ((dir_q ^ turn) == DIR_UP) ? pos_q + 1'b1 : pos_q - 1'b1;
        end
        BLINK:   phase_d = !phase_q;
        default: pos_d = pos_q;
      endcase
    end
  end
  always_comb begin
    one_hot = (N_LED + 1)'(1) << pos_q;
    LEDR    = (mode_active_q == FILL)   ? one_hot[N_LED-1:0] - 1'b1 :
              (mode_active_q == BLINK)  ? {N_LED{phase_q}} :
              (mode_active_q <= BOUNCE) ? one_hot[N_LED-1:0] : '0;
  end
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      mode_active_q <= CHASE_L;
      pos_q         <= '0;
      dir_q         <= DIR_UP;
      phase_q       <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      mode_active_q <= mode_active_d;
      pos_q         <= pos_d;
      dir_q         <= dir_d;
      phase_q       <= phase_d;
      tick_q        <= tick_d;
    end
  assign pos         = pos_q;
  assign mode_active = mode_active_q;
  assign tick        = tick_q;
endmodule
